// File: rtl/ro_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ro_counter
//  Description : Ring-oscillator frequency meter. Enables the oscillator,
//                lets it settle for SETTLE_CYCLES clk cycles, then counts
//                synchronized rising edges of ro_in over WINDOW_CYCLES clk
//                cycles and publishes the result with a one-cycle done pulse.
//                Optional macro RO_COUNTER_SATURATE_EN: saturating running
//                counter with sticky overflow; otherwise the counter wraps
//                and overflow is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_counter #(
    parameter int COUNT_WIDTH   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int WINDOW_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ro_in,
    output logic                   ro_enable,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    // One shared phase timer covers both SETTLE and COUNT; it only has to
    // reach the larger of the two lengths minus one.
    localparam int c_TIMER_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int c_TIMER_W   = (c_TIMER_MAX > 1) ? $clog2(c_TIMER_MAX) : 1;

    localparam logic [c_TIMER_W-1:0] c_SETTLE_LAST = c_TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_WINDOW_LAST = c_TIMER_W'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [COUNT_WIDTH-1:0] r_run;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_hist;
    logic                   w_edge;
    logic [COUNT_WIDTH-1:0] w_run_next;
    logic                   w_sat_next;
`ifdef RO_COUNTER_SATURATE_EN
    logic                   r_sat;
`endif

    // Two-flop synchronizer for the asynchronous oscillator plus a history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_hist;

    // Next value of the running edge counter (only committed during COUNT)
    always_comb begin
        w_run_next = r_run;
`ifdef RO_COUNTER_SATURATE_EN
        w_sat_next = r_sat;
        if (w_edge) begin
            if (&r_run) begin
                w_sat_next = 1'b1;
            end else begin
                w_run_next = r_run + COUNT_WIDTH'(1);
            end
        end
`else
        w_sat_next = 1'b0;
        if (w_edge) begin
            w_run_next = r_run + COUNT_WIDTH'(1);
        end
`endif
    end

    // Measurement FSM with registered status outputs; the result registers
    // load on the edge entering DONE so count is already valid while done=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_run     <= '0;
`ifdef RO_COUNTER_SATURATE_EN
            r_sat     <= 1'b0;
`endif
            ro_enable <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_SETTLE;
                        r_timer   <= '0;
                        r_run     <= '0;
`ifdef RO_COUNTER_SATURATE_EN
                        r_sat     <= 1'b0;
`endif
                        ro_enable <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    r_run <= '0;
                    if (r_timer == c_SETTLE_LAST) begin
                        r_state <= S_COUNT;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                S_COUNT: begin
                    r_run <= w_run_next;
`ifdef RO_COUNTER_SATURATE_EN
                    r_sat <= w_sat_next;
`endif
                    if (r_timer == c_WINDOW_LAST) begin
                        r_state   <= S_DONE;
                        r_timer   <= '0;
                        ro_enable <= 1'b0;
                        done      <= 1'b1;
                        count     <= w_run_next;
                        overflow  <= w_sat_next;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    ro_enable <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ro_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_counter
//  Description : Self-checking bench for ro_counter (SETTLE=4, WINDOW=100).
//                Expected results are queued at each start and compared at
//                each done pulse; cycle-level behaviour is checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic ro_in = 1'b0;

    logic        ro_enable, busy, done, overflow;
    logic [15:0] count;
    logic        ro_enable2, busy2, done2, overflow2;
    logic [3:0]  count2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] c;
        logic        o;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int   ro_period = 0;
    logic ro_const  = 1'b0;
    int   ro_ph     = 0;

    always #5 clk = ~clk;

    ro_counter #(.COUNT_WIDTH(16), .SETTLE_CYCLES(4), .WINDOW_CYCLES(100)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ro_in(ro_in),
        .ro_enable(ro_enable), .busy(busy), .done(done),
        .count(count), .overflow(overflow)
    );

    ro_counter #(.COUNT_WIDTH(4), .SETTLE_CYCLES(4), .WINDOW_CYCLES(100)) u_dut4 (
        .clk(clk), .rst(rst), .start(start2), .ro_in(ro_in),
        .ro_enable(ro_enable2), .busy(busy2), .done(done2),
        .count(count2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Oscillator model: square wave of ro_period clk cycles, or constant level
    always @(negedge clk) begin
        if (ro_period == 0) begin
            ro_in = ro_const;
        end else begin
            ro_ph = (ro_ph + 1) % ro_period;
            ro_in = (ro_ph < ro_period / 2);
        end
    end

    // Scoreboard: pop and compare whenever a DUT announces a result
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q1.size() == 0) begin
                check("dut16_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut16_count", {16'd0, count}, {16'd0, e.c});
                check("dut16_overflow", {31'd0, overflow}, {31'd0, e.o});
            end
        end
        if (!rst && done2) begin
            if (q2.size() == 0) begin
                check("dut4_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("dut4_count", {28'd0, count2}, {16'd0, e.c});
                check("dut4_overflow", {31'd0, overflow2}, {31'd0, e.o});
            end
        end
    end

    // Drive one start pulse; returns at the negedge after the sampling edge (k=0)
    task automatic pulse1(input logic [15:0] exp_c);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        e.c = exp_c;
        e.o = 1'b0;
        q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycle-by-cycle watch of the 16-bit DUT, k = cycles after the sampling edge.
    // s1/s2: cycles where a stray start is driven; rk: cycle where rst is driven.
    task automatic watch(input int n, input int done_k, input int s1, input int s2,
                         input int rk, input logic [15:0] hold, input int exp_ndone,
                         input string tag);
        int bad_en = 0, bad_busy = 0, bad_hold = 0, nd = 0, dk = -1;
        int hold_lim;
        logic exp_en, exp_busy;
        hold_lim = (rk >= 0) ? rk + 1 : done_k;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (rk >= 0 && k > rk) begin
                exp_en   = 1'b0;
                exp_busy = 1'b0;
            end else begin
                exp_en   = (k < 104);
                exp_busy = (k <= done_k);
            end
            if (ro_enable !== exp_en) bad_en++;
            if (busy !== exp_busy) bad_busy++;
            if (k < hold_lim && count !== hold) bad_hold++;
            if (done === 1'b1) begin
                nd++;
                dk = k;
            end
            if (rk >= 0 && k == rk + 1) q1.delete();
            start = (k == s1 || k == s2);
            rst   = (k == rk);
        end
        start = 1'b0;
        rst   = 1'b0;
        check({tag, "_ro_enable_cycles_bad"}, bad_en, 0);
        check({tag, "_busy_cycles_bad"}, bad_busy, 0);
        check({tag, "_count_hold_bad"}, bad_hold, 0);
        check({tag, "_done_pulses"}, nd, exp_ndone);
        if (exp_ndone == 1) check({tag, "_done_cycle"}, dk, done_k);
    endtask

    initial begin
        exp_t e2;
        int   seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ro_enable", {31'd0, ro_enable}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_count", {16'd0, count}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_count4", {28'd0, count2}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic measurement: period 10 over 100 cycles -> 10 edges
        ro_period = 10;
        repeat (12) @(negedge clk);
        pulse1(16'd10);
        watch(120, 104, -1, -1, -1, 16'd0, 1, "basic");

        // Stray starts during COUNT and DONE are ignored
        pulse1(16'd10);
        watch(130, 104, 19, 104, -1, 16'd10, 1, "ignore_start");

        // Back-to-back: restart the cycle after DONE with period 5 -> 20
        pulse1(16'd10);
        watch(105, 104, -1, -1, -1, 16'd10, 1, "b2b_first");
        ro_period = 5;
        pulse1(16'd20);
        watch(120, 104, -1, -1, -1, 16'd10, 1, "b2b_second");
        check("b2b_final_count", {16'd0, count}, 20);

        // Reset in the middle of COUNT aborts without a result
        ro_period = 10;
        pulse1(16'd0);
        watch(80, 104, -1, -1, 49, 16'd20, 0, "abort");
        check("abort_count_cleared", {16'd0, count}, 0);
        check("abort_queue_empty", q1.size(), 0);

        // Constant-high oscillator: no edges counted
        ro_period = 0;
        ro_const  = 1'b1;
        repeat (6) @(negedge clk);
        pulse1(16'd0);
        watch(120, 104, -1, -1, -1, 16'd0, 1, "const_high");

        // Edges only while IDLE, then quiet before start -> still 0
        ro_period = 4;
        repeat (20) @(negedge clk);
        ro_period = 0;
        ro_const  = 1'b0;
        repeat (6) @(negedge clk);
        pulse1(16'd0);
        watch(120, 104, -1, -1, -1, 16'd0, 1, "idle_edges");

        // 4-bit counter, period 4 -> 25 edges: saturate to 15 or wrap to 9
        ro_period = 4;
        repeat (8) @(negedge clk);
        start2 = 1'b1;
`ifdef RO_COUNTER_SATURATE_EN
        e2.c = 16'd15;
        e2.o = 1'b1;
`else
        e2.c = 16'd9;
        e2.o = 1'b0;
`endif
        q2.push_back(e2);
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        seen = 0;
        for (int k = 0; k < 300 && seen == 0; k++) begin
            if (done2 === 1'b1) seen = 1;
            else @(negedge clk);
        end
        check("dut4_done_seen", seen, 1);

        repeat (5) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/ro_counter.md
RO_COUNTER -- requirements
Module: ro_counter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of edge count result.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8, clk cycles the oscillator runs before counting starts (>=1).
REQ-003 SHALL have parameter WINDOW_CYCLES, default 1024, clk cycles in the counting window (>=1).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  measurement request; sampled only in IDLE.
REQ-007 SHALL have port ro_in  input  1  ring oscillator output; asynchronous to clk.
REQ-008 SHALL have port ro_enable  output  1  drives the ring oscillator enable input.
REQ-009 SHALL have port busy  output  1  high in SETTLE, COUNT and DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when count is valid.
REQ-011 SHALL have port count  output  COUNT_WIDTH  last measurement result.
REQ-012 SHALL have port overflow  output  1  last measurement exceeded 2^COUNT_WIDTH-1 (see Configuration).

Function
REQ-013 SHALL pass ro_in through a 2-flop synchronizer plus one history flop; edge pulse = synced & ~history.
REQ-014 SHALL implement FSM states IDLE, SETTLE, COUNT, DONE.
REQ-015 IDLE: start=1 -> SETTLE next cycle; otherwise stay.
REQ-016 SETTLE: lasts exactly SETTLE_CYCLES cycles, then COUNT; running edge counter held at 0.
REQ-017 COUNT: lasts exactly WINDOW_CYCLES cycles; each cycle with edge pulse=1 increments running counter by 1; then DONE.
REQ-018 DONE: lasts one cycle; done=1; count and overflow registers load final running result; next state IDLE.
REQ-019 ro_enable SHALL be 1 in SETTLE and COUNT only, 0 in IDLE and DONE.
REQ-020 Latency: start sampled at edge N -> done high in cycle starting at edge N+1+SETTLE_CYCLES+WINDOW_CYCLES.
REQ-021 start outside IDLE (incl. DONE) SHALL be ignored, not queued.
REQ-022 count and overflow SHALL hold their value from DONE until the next DONE; they do not change during a measurement.
REQ-023 Edge pulses in IDLE, SETTLE or DONE SHALL NOT affect the result.

Reset
REQ-024 rst=1 SHALL, at the next clk edge, force IDLE regardless of state, including mid-SETTLE/COUNT.
REQ-025 Reset values: ro_enable=0, busy=0, done=0, count=0, overflow=0, running counter=0, window/settle counter=0, synchronizer and history flops=0.
REQ-026 A measurement interrupted by reset SHALL produce no done pulse and SHALL NOT update count.

Configuration
REQ-027 Macro RO_COUNTER_SATURATE_EN defined: running counter SHALL saturate at 2^COUNT_WIDTH-1; an increment attempted at that value sets a sticky flag loaded into overflow at DONE.
REQ-028 Macro RO_COUNTER_SATURATE_EN undefined: running counter SHALL wrap modulo 2^COUNT_WIDTH; overflow SHALL be constant 0.

Verification
REQ-029 SETTLE=4, WINDOW=100, ro_in square wave period 10 clk, start pulse at edge N -> done at edge N+105, count=10, overflow=0, ro_enable high cycles N+1..N+104.
REQ-030 Same setup, start pulses at N+20 and N+105 -> exactly one done (N+105), busy continuous N+1..N+105, count=10.
REQ-031 Same setup, rst=1 at N+50 for one cycle -> IDLE at N+51, ro_enable=0, no done pulse, count retains prior value (0 after reset).
REQ-032 COUNT_WIDTH=4, WINDOW=100, ro_in period 4 clk -> with RO_COUNTER_SATURATE_EN: count=15, overflow=1; without: count=9 (25 mod 16), overflow=0.
REQ-033 ro_in held constant 1 throughout -> count=0 at done; edges toggled only in IDLE before start -> count=0.
REQ-034 Back-to-back: start again at the cycle after DONE, ro_in period 5 -> second done 105 cycles later, count=20; count stays 10 from first run until then.
